uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares a single UART transmitter between NUM_REQ byte producers, e.g. a debug console, a status reporter and a RAM dumper.
- Arbitrates round-robin, latches the winning byte, and runs the transmitter's go/bsy handshake:
  - assert go;
  - hold the data stable for the whole frame;
  - release go after bsy falls;
  - guarantee go is low for at least one cycle.
- Sits between the producers and the transmitter. The transmitter acts on the falling edge of clk; this block acts on the rising edge.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BSY_TIMEOUT, 16, max cycles to wait for uart_bsy to rise after go is asserted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  requester i has a byte; held with its data until req_ack[i]
- req_data  in  NUM_REQ*8  byte of requester i at bits [8*i+7:8*i]
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
- uart_data  out  8  byte to the transmitter, stable from go-high until go-low
- uart_go  out  1  transmitter start/acknowledge
- uart_bsy  in  1  transmitter busy
- busy  out  1  high in any state other than IDLE
- grant_idx  out  $clog2(NUM_REQ)  index of the requester currently or last served
- timeout_err  out  1  sticky; set on a bsy timeout, cleared only by rst

Behaviour:
- Reset values (rst sampled high at a rising edge):
  - state=IDLE; uart_go=0; uart_data=0; req_ack=0; busy=0; grant_idx=0; timeout_err=0.
  - Round-robin pointer reset so that requester 0 has highest priority.
- Reset mid-frame:
  - uart_go drops on the next edge and the latched byte is discarded; no ack is re-issued.
  - The transmitter shares the system reset, so both blocks restart together.
- IDLE:
  - If any req_valid is set, pick the winner: the first set index at or after the pointer, wrapping modulo NUM_REQ.
  - On the edge: uart_data <= winner's byte; grant_idx <= winner; req_ack[winner] <= 1 for exactly one cycle; uart_go <= 1; pointer <= (winner+1) mod NUM_REQ; state <= START.
  - With no valid: remain in IDLE, all outputs held.
- START:
  - uart_go=1. Wait for uart_bsy=1, then go to SEND.
  - A cycle counter starts at 0. If uart_bsy is still 0 when the counter reaches BSY_TIMEOUT-1: set timeout_err, go to RELEASE.
- SEND:
  - uart_go=1; uart_data held. Wait for uart_bsy=0, then go to RELEASE.
  - There is no timeout in SEND; frame length depends on baud rate.
- RELEASE:
  - uart_go=0 for exactly one cycle, then go to IDLE.
  - The earliest next uart_go is one cycle after RELEASE, so go is low for at least one full cycle between frames.
- Latency:
  - req_valid high with block idle -> req_ack and uart_go high on the next edge (1 cycle).
  - Frame end -> next grant: 2 cycles (RELEASE, then IDLE).
- req_ack is registered and never asserted for more than one requester or for more than one cycle.
- Requesters change data or drop valid only after sampling ack. Valid still high after ack means a new byte.
- Simultaneous requests: serviced strictly round-robin. With requesters 0 and 2 continuously valid, the grant order is 0,2,0,2.
- A valid that drops before grant is ignored without error.
- uart_data changes only in IDLE.

Decomposition:
- Package uart_tx_arbiter_pkg:
  - state enum {IDLE, START, SEND, RELEASE};
  - timeout counter width function;
  - DATA_WIDTH=8.
- Sub-module rr_picker (combinational):
  - inputs: valid vector, pointer;
  - outputs: any_valid, winner index;
  - implemented as a doubled-vector priority scan.

Test Plan:
- Single byte: req_valid[1]=1, req_data[1]=0x41, transmitter model at BIT_TIME=4 -> req_ack[1] one-cycle pulse one edge later; uart_data=0x41 and uart_go=1 until uart_bsy falls; then uart_go=0 for >=1 cycle; tx line shows 0x41 framed 8N1.
- Contention: all three valid with 0x10,0x11,0x12 held continuously -> grant order 0,1,2,0; ack pulses in that order; no overlapping acks.
- Pointer fairness: requester 0 always valid, requester 2 valid after the first grant -> second grant goes to 2, not 0.
- Back-to-back gap: requester 0 streams 4 bytes -> each frame separated by uart_go low for >=1 cycle; every byte received in order.
- Timeout: transmitter stub keeps uart_bsy=0 -> after BSY_TIMEOUT=16 cycles, timeout_err=1 (sticky); block returns to IDLE and serves the next request.
- Reset mid-frame: rst=1 during SEND -> next edge uart_go=0, busy=0, grant_idx=0, timeout_err=0; after release, requester 0 wins over requester 2 when both are valid.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types and sizing helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {IDLE, START, SEND, RELEASE} state_t;

   // Width of a counter that must reach limit-1; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: round-robin winner select, first valid index at or after ptr, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 3,
   localparam int W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [W-1:0]       ptr,
   output logic               any_valid,
   output logic [W-1:0]       winner
);

   logic [2*NUM_REQ-1:0] dbl;

   // Scan the doubled vector from the far end so the nearest hit to ptr lands last.
   always_comb begin
      dbl = {valid, valid};
      any_valid = |valid;
      winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (dbl[int'(ptr) + i]) winner = W'((int'(ptr) + i) % NUM_REQ);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with a go/bsy handshake.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int BSY_TIMEOUT = 16,
   localparam int W = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ack,
   output logic [DATA_WIDTH-1:0]          uart_data,
   output logic                           uart_go,
   input  logic                           uart_bsy,
   output logic                           busy,
   output logic [W-1:0]                   grant_idx,
   output logic                           timeout_err
);

   localparam int CW = cnt_width(BSY_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(BSY_TIMEOUT - 1);

   state_t state, state_n;
   logic [W-1:0] ptr, winner;
   logic any_valid, grant, bsy_expired;
   logic [CW-1:0] cnt;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid(req_valid),
      .ptr(ptr),
      .any_valid(any_valid),
      .winner(winner)
   );

   assign grant = state == IDLE && any_valid;
   assign bsy_expired = state == START && !uart_bsy && cnt == CNT_LAST;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = any_valid ? START : IDLE;
         START:   state_n = uart_bsy ? SEND : bsy_expired ? RELEASE : START;
         SEND:    state_n = uart_bsy ? SEND : RELEASE;
         default: state_n = IDLE;
      endcase
      uart_go = state == START || state == SEND;
      busy = state != IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         cnt <= '0;
         req_ack <= '0;
         uart_data <= '0;
         grant_idx <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= state == START ? cnt + 1'b1 : '0;
         req_ack <= grant ? NUM_REQ'(1) << winner : '0;
         if (bsy_expired) timeout_err <= 1'b1;
         if (grant) begin
            uart_data <= req_data[DATA_WIDTH*winner +: DATA_WIDTH];
            grant_idx <= winner;
            ptr <= winner == W'(NUM_REQ - 1) ? '0 : winner + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks against a queue-based arbitration and transmitter model.
module tb_uart_tx_arbiter;

   localparam int N = 3, TO = 16, BT = 4;

   logic clk = 0, rst = 1;
   logic [N-1:0] req_valid = '0, req_ack;
   logic [N*8-1:0] req_data = '0;
   logic [7:0] uart_data;
   logic uart_go, busy, timeout_err;
   logic uart_bsy = 0;
   logic [1:0] grant_idx;

   uart_tx_arbiter #(.NUM_REQ(N), .BSY_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
      .uart_data(uart_data), .uart_go(uart_go), .uart_bsy(uart_bsy), .busy(busy),
      .grant_idx(grant_idx), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int vectors = 0, errors = 0;
   logic [7:0] pq [N][$];
   logic [7:0] exp_q[$], rx_q[$];
   int gl[$];
   logic [N-1:0] en = '1;
   int mptr = 0, lowrun = 0, nframes = 0;
   logic busy_p = 0, go_p = 0, gap_chk = 0, stub = 0;
   logic [7:0] cur = 0;

   // Transmitter stand-in: acts on the falling edge, 10 bit times per frame, bits taken live from uart_data.
   logic twait = 0;
   int tcnt = 0;
   logic [7:0] sh = 0;
   always @(negedge clk) begin
      if (rst) begin
         uart_bsy <= 0;
         twait <= 0;
      end else if (twait) twait <= uart_go;
      else if (!uart_bsy) begin
         if (uart_go && !stub) begin
            uart_bsy <= 1;
            tcnt <= 0;
         end
      end else begin
         tcnt <= tcnt + 1;
         if (tcnt % BT == BT / 2 && tcnt / BT >= 1 && tcnt / BT <= 8) sh[tcnt/BT-1] <= uart_data[tcnt/BT-1];
         if (tcnt == 10 * BT - 1) begin
            uart_bsy <= 0;
            twait <= 1;
            rx_q.push_back(sh);
         end
      end
   end

   task automatic check(input string tag, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (pq[i].size() > 0) return 1;
      return 0;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = en[i] && pq[i].size() > 0;
         req_data[8*i +: 8] = pq[i].size() > 0 ? pq[i][0] : 8'($urandom);
      end
   endtask

   task automatic tick();
      logic [N-1:0] v = req_valid;
      logic [N*8-1:0] d = req_data;
      logic r = rst;
      int w = -1;
      int exp_ack = 0;
      @(posedge clk);
      #1;
      check("ack_onehot", int'($onehot0(req_ack)), 1);
      if (r) begin
         mptr = 0;
         check("rst_ack", int'(req_ack), 0);
         check("rst_go", int'(uart_go), 0);
         check("rst_busy", int'(busy), 0);
      end else begin
         for (int k = 0; k < N; k++) if (w < 0 && v[(mptr+k)%N]) w = (mptr + k) % N;
         if (!busy_p && w >= 0) exp_ack = 1 << w;
         check("ack", int'(req_ack), exp_ack);
         if (exp_ack != 0) begin
            check("grant_idx", int'(grant_idx), w);
            check("grant_data", int'(uart_data), int'(d[8*w +: 8]));
            check("grant_go", int'(uart_go), 1);
            cur = d[8*w +: 8];
            mptr = (w + 1) % N;
            gl.push_back(w);
            exp_q.push_back(pq[w].pop_front());
         end
         if (uart_go) check("data_hold", int'(uart_data), int'(cur));
         if (!uart_go && go_p) check("release_busy", int'(busy), 1);
         if (uart_go && !go_p) begin
            if (gap_chk && nframes > 0) check("gap", lowrun, 2);
            nframes++;
         end
      end
      lowrun = uart_go ? 0 : lowrun + 1;
      busy_p = busy;
      go_p = uart_go;
      drive();
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (n < limit && (busy || uart_bsy || pending())) begin
         tick();
         n++;
      end
      check("idle_reached", int'(n < limit), 1);
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check(tag, int'(rx_q[i]), int'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
      gl.delete();
   endtask

   initial begin
      int n;
      drive();
      tick();
      do_reset();
      check("rst_data", int'(uart_data), 0);
      check("rst_grant", int'(grant_idx), 0);
      check("rst_terr", int'(timeout_err), 0);

      pq[1].push_back(8'h41);
      drive();
      tick();
      check("single_ack", int'(req_ack), 3'b010);
      check("single_go", int'(uart_go), 1);
      tick();
      check("single_pulse", int'(req_ack), 0);
      wait_idle(400);
      check_rx("single_rx");

      do_reset();
      for (int i = 0; i < N; i++) repeat (2) pq[i].push_back(8'h10 + 8'(i));
      drive();
      wait_idle(600);
      check("cont_n", gl.size(), 6);
      for (int i = 0; i < 4 && i < gl.size(); i++) check("cont_order", gl[i], i % N);
      check_rx("cont_rx");

      do_reset();
      repeat (3) pq[0].push_back(8'($urandom));
      drive();
      tick();
      pq[2].push_back(8'h22);
      drive();
      wait_idle(600);
      if (gl.size() > 1) check("fair_second", gl[1], 2);
      else check("fair_count", gl.size(), 2);
      check_rx("fair_rx");

      gap_chk = 1;
      nframes = 0;
      repeat (4) pq[0].push_back(8'($urandom));
      drive();
      wait_idle(600);
      check("stream_frames", nframes, 4);
      gap_chk = 0;
      check_rx("stream_rx");

      stub = 1;
      pq[1].push_back(8'h55);
      drive();
      tick();
      check("to_ack", int'(req_ack), 3'b010);
      exp_q.delete();
      repeat (TO - 1) tick();
      check("to_early", int'(timeout_err), 0);
      check("to_go_held", int'(uart_go), 1);
      tick();
      check("to_set", int'(timeout_err), 1);
      check("to_release", int'(uart_go), 0);
      stub = 0;
      tick();
      check("to_idle", int'(busy), 0);
      pq[2].push_back(8'h66);
      drive();
      wait_idle(400);
      check("to_sticky", int'(timeout_err), 1);
      check_rx("to_rx");

      pq[1].push_back(8'h77);
      drive();
      n = 0;
      while (n < 20 && !(busy && uart_go && uart_bsy)) begin
         tick();
         n++;
      end
      check("send_reached", int'(n < 20), 1);
      tick();
      do_reset();
      check("mid_go", int'(uart_go), 0);
      check("mid_grant", int'(grant_idx), 0);
      check("mid_terr", int'(timeout_err), 0);
      exp_q.delete();
      rx_q.delete();
      gl.delete();
      pq[0].push_back(8'h01);
      pq[2].push_back(8'h02);
      drive();
      tick();
      check("mid_prio", int'(req_ack), 3'b001);
      wait_idle(600);
      check_rx("mid_rx");

      for (int c = 0; c < 3000; c++) begin
         int r = $urandom_range(0, N - 1);
         if ($urandom_range(0, 5) == 0 && pq[r].size() < 3) pq[r].push_back(8'($urandom));
         for (int i = 0; i < N; i++) en[i] = $urandom_range(0, 3) != 0;
         drive();
         tick();
      end
      en = '1;
      drive();
      wait_idle(5000);
      check_rx("rand_rx");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
